if_id_queue: RTL and testbench

//  Parametrised IF->ID boundary: DEPTH-entry instruction queue, next generation of the single IF/ID register.

---
 rtl/if_id_queue.sv | 67 ++++++
 tb/tb_if_id_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID instruction queue with flush and NOP bubble on empty
module if_id_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inst_valid_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic [DATA_W-1:0]        inst_i,
  output logic                     inst_ready_o,
  input  logic                     flush_i,
  input  logic                     stall_i,
  output logic                     inst_valid_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic [DATA_W-1:0]        inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Flow control is derived from occupancy only; a full queue never accepts
  // a push even when the head is leaving in the same cycle.
  assign inst_ready_o = (count != CNT_W'(DEPTH));
  assign inst_valid_o = (count != '0);
  assign push         = inst_valid_i & inst_ready_o;
  assign pop          = inst_valid_o & ~stall_i;
  assign count_o      = count;

  // Head is read straight from storage; an empty queue shows a NOP bubble.
  assign inst_addr_o  = inst_valid_o ? addr_mem[rd_ptr] : '0;
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : NOP_INST;

  // Entry storage: no reset needed, contents are only observed while counted.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      addr_mem[wr_ptr] <= inst_addr_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end

  // Pointers and occupancy: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue model
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        inst_ready_o;
  logic        flush_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic [2:0]  count_o;

  if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_valid_i (inst_valid_i),
    .inst_addr_i  (inst_addr_i),
    .inst_i       (inst_i),
    .inst_ready_o (inst_ready_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .inst_valid_o (inst_valid_o),
    .inst_addr_o  (inst_addr_o),
    .inst_o       (inst_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare every output against what the model queue currently holds.
  task automatic check_outputs();
    logic [31:0] ea;
    logic [31:0] ed;
    ea = (mq.size() != 0) ? mq[0].a : 32'h0;
    ed = (mq.size() != 0) ? mq[0].d : NOP;
    chk("valid", 64'(inst_valid_o), 64'(mq.size() != 0));
    chk("ready", 64'(inst_ready_o), 64'(mq.size() < DEPTH));
    chk("count", 64'(count_o),      64'(mq.size()));
    chk("addr",  64'(inst_addr_o),  64'(ea));
    chk("inst",  64'(inst_o),       64'(ed));
  endtask

  // One cycle: apply inputs, check current outputs, clock, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic st, input logic fl, input logic rs);
    bit do_push;
    bit do_pop;
    @(negedge clk_i);
    inst_valid_i = v;
    inst_addr_i  = a;
    inst_i       = d;
    stall_i      = st;
    flush_i      = fl;
    rst_i        = rs;
    #1;
    check_outputs();
    @(posedge clk_i);
    if (rs || fl) begin
      mq.delete();
    end else begin
      do_push = v && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && !st;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{a: a, d: d});
    end
  endtask

  initial begin
    rst_i = 1'b1; inst_valid_i = 1'b0; inst_addr_i = '0; inst_i = '0;
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    mq.delete();

    // Scenario 1: reset values against literal constants.
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst",  64'(inst_o),       64'h13);
    chk("rst_addr",  64'(inst_addr_o),  64'd0);
    chk("rst_ready", 64'(inst_ready_o), 64'd1);
    chk("rst_count", 64'(count_o),      64'd0);

    // Scenario 2: single push, visible next cycle, then popped.
    step(1, 32'h100, 32'hAAAA0001, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Scenario 3: fill under stall, fifth push refused and retried.
    step(1, 32'h100, 32'h1000_0000, 1, 0, 0);
    step(1, 32'h104, 32'h1000_0004, 1, 0, 0);
    step(1, 32'h108, 32'h1000_0008, 1, 0, 0);
    step(1, 32'h10C, 32'h1000_000C, 1, 0, 0);
    step(1, 32'h110, 32'h1000_0010, 1, 0, 0);
    chk("full_head", 64'(inst_addr_o), 64'h100);

    // Scenario 4: release stall, hold 0x110 then stream past pointer wrap.
    step(1, 32'h110, 32'h1000_0010, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(1, 32'h110 + 32'(4 * i), 32'h1000_0010 + 32'(4 * i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

    // Scenario 5: three entries, flush with simultaneous push.
    step(1, 32'h180, 32'h2000_0000, 1, 0, 0);
    step(1, 32'h184, 32'h2000_0004, 1, 0, 0);
    step(1, 32'h188, 32'h2000_0008, 1, 0, 0);
    step(1, 32'h200, 32'h3000_0000, 1, 1, 0);
    step(1, 32'h300, 32'h4000_0000, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("after_flush_head", 64'(inst_addr_o), 64'h300);

    // Scenario 6: reset while full and stalled.
    for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4 * i), 32'(i), 1, 0, 0);
    step(1, 32'h500, 32'h5, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 70),
           $urandom, $urandom,
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 2));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
